// File: rtl/mem_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types and constants for the unified-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_t;

    localparam int WORD_BYTES = 4;
    localparam int DATA_W     = 8 * WORD_BYTES;

    // Request fields captured at grant; the word address is held separately
    // because its width depends on the arbiter's ADDR_W parameter.
    typedef struct packed {
        req_id_t               id;
        logic                  we;
        logic [DATA_W-1:0]     wdata;
        logic [WORD_BYTES-1:0] wstrb;
    } req_t;

    function automatic logic [WORD_BYTES-1:0] write_mask(
        input logic                  we,
        input logic [WORD_BYTES-1:0] wstrb
    );
        return we ? wstrb : '0;
    endfunction

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_arb_if
// Brief    : Fetch, load/store and memory-side signal bundle of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_arb_if #(
    parameter int ADDR_W = 10
) ();

    logic              if_req_valid;
    logic [31:0]       if_addr;
    logic              if_req_ready;
    logic              if_rsp_valid;
    logic [31:0]       if_rdata;

    logic              d_req_valid;
    logic [31:0]       d_addr;
    logic              d_we;
    logic [31:0]       d_wdata;
    logic [3:0]        d_wstrb;
    logic              d_req_ready;
    logic              d_rsp_valid;
    logic [31:0]       d_rdata;

    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    // Arbiter view
    modport slave (
        input  if_req_valid, if_addr,
        output if_req_ready, if_rsp_valid, if_rdata,
        input  d_req_valid, d_addr, d_we, d_wdata, d_wstrb,
        output d_req_ready, d_rsp_valid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requester and memory view
    modport master (
        output if_req_valid, if_addr,
        input  if_req_ready, if_rsp_valid, if_rdata,
        output d_req_valid, d_addr, d_we, d_wdata, d_wstrb,
        input  d_req_ready, d_rsp_valid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface : mem_arb_if
`default_nettype wire

// File: rtl/mem_arb_age_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_arb_age_counter
// Brief    : Saturating count of lost IF arbitrations; raises o_force at limit.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_age_counter #(
    parameter int AGE_LIMIT = 4,
    parameter int AGE_W     = 3
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_inc,
    input  wire logic             i_clr,
    output logic      [AGE_W-1:0] o_age,
    output logic                  o_force
);

    generate
        if (AGE_LIMIT == 0) begin : g_pure_priority
            logic w_unused_inputs;
            assign w_unused_inputs = ^{clk, reset, i_inc, i_clr};
            assign o_age   = '0;
            assign o_force = 1'b0;
        end else begin : g_aging
            localparam logic [AGE_W-1:0] c_LIMIT = AGE_W'(AGE_LIMIT);
            logic [AGE_W-1:0] r_age;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_age <= '0;
                end else if (i_clr) begin
                    r_age <= '0;
                end else if (i_inc && (r_age != c_LIMIT)) begin
                    r_age <= r_age + 1'b1;
                end
            end

            assign o_age   = r_age;
            assign o_force = (r_age >= c_LIMIT);
        end
    endgenerate

endmodule : mem_arb_age_counter
`default_nettype wire

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Single-outstanding arbiter sharing unified memory between IF and D.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int MEM_LATENCY = 1,
    parameter int AGE_LIMIT   = 4
) (
    input wire logic  clk,
    input wire logic  reset,
    mem_arb_if.slave  bus
);

    localparam int c_LAT_W = $clog2(MEM_LATENCY + 1);
    localparam int c_AGE_W = (AGE_LIMIT > 0) ? $clog2(AGE_LIMIT + 1) : 1;
    localparam logic [c_LAT_W-1:0] c_LAT_LAST = c_LAT_W'(MEM_LATENCY);
    localparam logic [c_LAT_W-1:0] c_LAT_ONE  = c_LAT_W'(1);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    req_t                r_req;
    logic [ADDR_W-1:0]   r_word_addr;
    logic [c_LAT_W-1:0]  r_lat_cnt;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_d_rdata;

    logic                w_grant_if;
    logic                w_grant_d;
    logic                w_lat_done;
    logic                w_age_inc;
    logic                w_age_force;
    logic [c_AGE_W-1:0]  w_age;
    logic                w_unused_addr_bits;

    // Byte offset and bits above the memory depth are intentionally dropped.
    assign w_unused_addr_bits = ^{bus.if_addr, bus.d_addr};

    // ------------------------------------------------------------------
    // Arbitration: D wins unless IF has aged past the limit.
    // ------------------------------------------------------------------
    always_comb begin
        w_grant_if = 1'b0;
        w_grant_d  = 1'b0;
        if (reset && (r_state == IDLE)) begin
            if (bus.d_req_valid && !(bus.if_req_valid && w_age_force)) begin
                w_grant_d = 1'b1;
            end else if (bus.if_req_valid) begin
                w_grant_if = 1'b1;
            end
        end
    end

    assign w_age_inc  = reset && (r_state == IDLE) && bus.if_req_valid && !w_grant_if;
    assign w_lat_done = (r_lat_cnt == c_LAT_LAST);

    mem_arb_age_counter #(
        .AGE_LIMIT (AGE_LIMIT),
        .AGE_W     (c_AGE_W)
    ) u_age (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_age_inc),
        .i_clr   (w_grant_if),
        .o_age   (w_age),
        .o_force (w_age_force)
    );

    // ------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        bus.if_req_ready = w_grant_if;
        bus.d_req_ready  = w_grant_d;
        bus.if_rsp_valid = 1'b0;
        bus.d_rsp_valid  = 1'b0;
        bus.if_rdata     = r_if_rdata;
        bus.d_rdata      = r_d_rdata;
        bus.mem_en       = 1'b0;
        bus.mem_we       = '0;
        bus.mem_addr     = r_word_addr;
        bus.mem_wdata    = r_req.wdata;

        case (r_state)
            IDLE: begin
                if (w_grant_if || w_grant_d) begin
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                bus.mem_en = 1'b1;
                bus.mem_we = write_mask(r_req.we, r_req.wstrb);
                if (w_lat_done) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                bus.if_rsp_valid = (r_req.id == REQ_IF);
                bus.d_rsp_valid  = (r_req.id == REQ_D);
                w_state_nxt      = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, request latch, latency counter and response data
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_req       <= '0;
            r_word_addr <= '0;
            r_lat_cnt   <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_grant_d) begin
                r_req       <= '{id: REQ_D, we: bus.d_we, wdata: bus.d_wdata, wstrb: bus.d_wstrb};
                r_word_addr <= bus.d_addr[ADDR_W+1:2];
                r_lat_cnt   <= c_LAT_ONE;
            end else if (w_grant_if) begin
                r_req       <= '{id: REQ_IF, we: 1'b0, wdata: '0, wstrb: '0};
                r_word_addr <= bus.if_addr[ADDR_W+1:2];
                r_lat_cnt   <= c_LAT_ONE;
            end else if ((r_state == ACCESS) && !w_lat_done) begin
                r_lat_cnt <= r_lat_cnt + 1'b1;
            end

            // Stores return zero data; the data registers otherwise hold.
            if ((r_state == ACCESS) && w_lat_done) begin
                if (r_req.id == REQ_IF) begin
                    r_if_rdata <= bus.mem_rdata;
                end else begin
                    r_d_rdata <= r_req.we ? '0 : bus.mem_rdata;
                end
            end
        end
    end

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench: vector table plus multi-cycle corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W    = 10;
    localparam int ML0       = 1;
    localparam int ML1       = 3;
    localparam int AGE_LIMIT = 4;
    localparam logic [31:0] c_GARBAGE = 32'hBAD0BAD0;

    logic clk = 1'b0;
    logic reset;
    logic mem_init;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    mem_arb_if #(.ADDR_W(ADDR_W)) bus0 ();
    mem_arb_if #(.ADDR_W(ADDR_W)) bus1 ();

    mem_arbiter #(.ADDR_W(ADDR_W), .MEM_LATENCY(ML0), .AGE_LIMIT(AGE_LIMIT)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0));
    mem_arbiter #(.ADDR_W(ADDR_W), .MEM_LATENCY(ML1), .AGE_LIMIT(AGE_LIMIT)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1));

    // Memory models: data is only correct once mem_en has been held long enough.
    logic [31:0] mem0 [1024];
    logic [31:0] mem1 [1024];
    int cnt0, cnt1;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) begin
                mem0[i] <= 32'hA5000000 | i;
                mem1[i] <= 32'hA5000000 | i;
            end
            mem0[0]  <= 32'h00012083;
            mem0[42] <= 32'hdeadbeef;
            mem1[0]  <= 32'h600DF00D;
            cnt0 <= 0;
            cnt1 <= 0;
        end else begin
            if (bus0.mem_en) begin
                for (int b = 0; b < 4; b++)
                    if (bus0.mem_we[b]) mem0[bus0.mem_addr][8*b +: 8] <= bus0.mem_wdata[8*b +: 8];
                cnt0 <= cnt0 + 1;
            end else cnt0 <= 0;
            if (bus1.mem_en) begin
                for (int b = 0; b < 4; b++)
                    if (bus1.mem_we[b]) mem1[bus1.mem_addr][8*b +: 8] <= bus1.mem_wdata[8*b +: 8];
                cnt1 <= cnt1 + 1;
            end else cnt1 <= 0;
        end
    end

    assign bus0.mem_rdata = (bus0.mem_en && cnt0 >= ML0 - 1) ? mem0[bus0.mem_addr] : c_GARBAGE;
    assign bus1.mem_rdata = (bus1.mem_en && cnt1 >= ML1 - 1) ? mem1[bus1.mem_addr] : c_GARBAGE;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus0.if_req_valid = 1'b0; bus0.if_addr = '0;
        bus0.d_req_valid  = 1'b0; bus0.d_addr  = '0; bus0.d_we = 1'b0;
        bus0.d_wdata = '0; bus0.d_wstrb = '0;
        bus1.if_req_valid = 1'b0; bus1.if_addr = '0;
        bus1.d_req_valid  = 1'b0; bus1.d_addr  = '0; bus1.d_we = 1'b0;
        bus1.d_wdata = '0; bus1.d_wstrb = '0;
    endtask

    typedef struct {
        string       name;
        logic        is_d;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_maddr;
        logic [3:0]  exp_mwe;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [10];

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic exp_if;
        int   grants, last_cyc;

        vecs[0] = '{"if_fetch0",     1'b0, 32'h0000_0000, 1'b0, 32'h0,         4'h0, 32'd0,    4'h0, 32'h00012083};
        vecs[1] = '{"d_load42",      1'b1, 32'd168,       1'b0, 32'h0,         4'h0, 32'd42,   4'h0, 32'hdeadbeef};
        vecs[2] = '{"d_store2",      1'b1, 32'd8,         1'b1, 32'h12345678,  4'h3, 32'd2,    4'h3, 32'h0};
        vecs[3] = '{"d_reload2",     1'b1, 32'd8,         1'b0, 32'h0,         4'h0, 32'd2,    4'h0, 32'hA5005678};
        vecs[4] = '{"if_wrap",       1'b0, 32'h0000_1003, 1'b0, 32'h0,         4'h0, 32'd0,    4'h0, 32'h00012083};
        vecs[5] = '{"d_store_top",   1'b1, 32'h0000_0FFC, 1'b1, 32'hCAFEF00D,  4'hF, 32'd1023, 4'hF, 32'h0};
        vecs[6] = '{"if_top",        1'b0, 32'h0000_0FFC, 1'b0, 32'h0,         4'h0, 32'd1023, 4'h0, 32'hCAFEF00D};
        vecs[7] = '{"d_store_hi",    1'b1, 32'h0000_0010, 1'b1, 32'h11223344,  4'h8, 32'd4,    4'h8, 32'h0};
        vecs[8] = '{"d_load_unalgn", 1'b1, 32'h0000_0012, 1'b0, 32'h0,         4'h0, 32'd4,    4'h0, 32'h11000004};
        vecs[9] = '{"d_load_wrap",   1'b1, 32'hFFFF_F0A8, 1'b0, 32'h0,         4'h0, 32'd42,   4'h0, 32'hdeadbeef};

        clear_inputs();
        reset    = 1'b0;
        mem_init = 1'b1;
        repeat (3) @(negedge clk);

        chk("reset.state",    32'(dut0.r_state), 32'(IDLE));
        chk("reset.mem_en",   bus0.mem_en, 0);
        chk("reset.mem_we",   bus0.mem_we, 0);
        chk("reset.mem_addr", bus0.mem_addr, 0);
        chk("reset.rsp",      {bus0.if_rsp_valid, bus0.d_rsp_valid}, 0);
        chk("reset.rdata_if", bus0.if_rdata, 0);
        chk("reset.rdata_d",  bus0.d_rdata, 0);
        chk("reset.age",      32'(dut0.w_age), 0);
        reset    = 1'b1;
        mem_init = 1'b0;
        @(negedge clk);

        // ---------------- single-requester vector table (dut0) ----------------
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].is_d) begin
                bus0.d_req_valid = 1'b1; bus0.d_addr = vecs[i].addr; bus0.d_we = vecs[i].we;
                bus0.d_wdata = vecs[i].wdata; bus0.d_wstrb = vecs[i].wstrb;
            end else begin
                bus0.if_req_valid = 1'b1; bus0.if_addr = vecs[i].addr;
            end
            #1;
            chk({vecs[i].name, ".ready"},       vecs[i].is_d ? bus0.d_req_ready : bus0.if_req_ready, 1);
            chk({vecs[i].name, ".other_ready"}, vecs[i].is_d ? bus0.if_req_ready : bus0.d_req_ready, 0);
            @(negedge clk);
            clear_inputs();
            chk({vecs[i].name, ".mem_en"},   bus0.mem_en, 1);
            chk({vecs[i].name, ".mem_addr"}, bus0.mem_addr, vecs[i].exp_maddr);
            chk({vecs[i].name, ".mem_we"},   bus0.mem_we, vecs[i].exp_mwe);
            chk({vecs[i].name, ".early_rsp"}, {bus0.if_rsp_valid, bus0.d_rsp_valid}, 0);
            @(negedge clk);
            chk({vecs[i].name, ".rsp_valid"}, {bus0.if_rsp_valid, bus0.d_rsp_valid},
                vecs[i].is_d ? 32'd1 : 32'd2);
            chk({vecs[i].name, ".rdata"}, vecs[i].is_d ? bus0.d_rdata : bus0.if_rdata, vecs[i].exp_rdata);
            chk({vecs[i].name, ".mem_en_off"}, bus0.mem_en, 0);
            @(negedge clk);
            chk({vecs[i].name, ".rsp_pulse"}, {bus0.if_rsp_valid, bus0.d_rsp_valid}, 0);
        end

        // ---------------- aging: D,D,D,D then IF under continuous traffic ----------------
        bus0.if_req_valid = 1'b1; bus0.if_addr = 32'h0;
        bus0.d_req_valid  = 1'b1; bus0.d_addr  = 32'd168; bus0.d_we = 1'b0;
        grants   = 0;
        last_cyc = 0;
        for (int cyc = 0; cyc < 40 && grants < 5; cyc++) begin
            #1;
            if (bus0.if_req_ready || bus0.d_req_ready) begin
                exp_if = (grants == 4);
                chk($sformatf("age_arb.grant%0d_if", grants), bus0.if_req_ready, exp_if);
                chk($sformatf("age_arb.grant%0d_d", grants),  bus0.d_req_ready, !exp_if);
                chk($sformatf("age_arb.grant%0d_age", grants), 32'(dut0.w_age), grants);
                if (grants > 0) chk($sformatf("age_arb.spacing%0d", grants), cyc - last_cyc, 3);
                last_cyc = cyc;
                grants++;
            end
            @(negedge clk);
        end
        chk("age_arb.grant_count", grants, 5);
        clear_inputs();
        chk("age_arb.age_cleared", 32'(dut0.w_age), 0);
        repeat (2) @(negedge clk);

        // ---------------- request during ACCESS/RESP waits; dropped valid ----------------
        bus0.d_req_valid = 1'b1; bus0.d_addr = 32'd168;
        #1;
        chk("wait.d_ready", bus0.d_req_ready, 1);
        @(negedge clk);
        clear_inputs();
        bus0.if_req_valid = 1'b1;
        #1;
        chk("wait.if_ready_access", bus0.if_req_ready, 0);
        @(negedge clk);
        #1;
        chk("wait.if_ready_resp", bus0.if_req_ready, 0);
        chk("wait.d_rsp", bus0.d_rsp_valid, 1);
        chk("wait.d_rdata", bus0.d_rdata, 32'hdeadbeef);
        bus0.if_req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("drop.mem_en", bus0.mem_en, 0);
        chk("drop.age", 32'(dut0.w_age), 0);

        // ---------------- reset in the middle of ACCESS ----------------
        bus0.if_req_valid = 1'b1; bus0.d_req_valid = 1'b1; bus0.d_addr = 32'd168;
        #1;
        chk("rst_mid.d_ready", bus0.d_req_ready, 1);
        @(negedge clk);
        clear_inputs();
        chk("rst_mid.state_access", 32'(dut0.r_state), 32'(ACCESS));
        chk("rst_mid.age_before", 32'(dut0.w_age), 1);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid.no_rsp", bus0.d_rsp_valid, 0);
        chk("rst_mid.state", 32'(dut0.r_state), 32'(IDLE));
        chk("rst_mid.mem_en", bus0.mem_en, 0);
        chk("rst_mid.age", 32'(dut0.w_age), 0);
        chk("rst_mid.d_rdata", bus0.d_rdata, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid.no_rsp_late", bus0.d_rsp_valid, 0);

        // ---------------- MEM_LATENCY=3 with wrapped address (dut1) ----------------
        bus1.d_req_valid = 1'b1; bus1.d_addr = 32'h0000_1000; bus1.d_we = 1'b0;
        #1;
        chk("lat3.ready_t0", bus1.d_req_ready, 1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("lat3.mem_en_t%0d", k),   bus1.mem_en, 1);
            chk($sformatf("lat3.mem_addr_t%0d", k), bus1.mem_addr, 0);
            chk($sformatf("lat3.rsp_t%0d", k),      bus1.d_rsp_valid, 0);
            chk($sformatf("lat3.ready_t%0d", k),    bus1.d_req_ready, 0);
        end
        @(negedge clk);
        #1;
        chk("lat3.rsp_t4",   bus1.d_rsp_valid, 1);
        chk("lat3.rdata_t4", bus1.d_rdata, 32'h600DF00D);
        chk("lat3.ready_t4", bus1.d_req_ready, 0);
        @(negedge clk);
        #1;
        chk("lat3.ready_t5", bus1.d_req_ready, 1);
        @(negedge clk);
        clear_inputs();
        repeat (5) @(negedge clk);
        chk("lat3.idle_after", 32'(dut1.r_state), 32'(IDLE));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
